// File: rtl/reg32_rr_arbiter_pkg.sv
// rtl/reg32_rr_arbiter_pkg.sv - shared state encoding and default parameters for the register arbiter
package reg32_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/reg32_rr_arbiter_rr_pick.sv
// rtl/reg32_rr_arbiter_rr_pick.sv - combinational rotating-priority encoder
// First set req bit at or after ptr (wrapping) wins.
module rr_pick
    import reg32_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     pick_valid,
    output logic [$clog2(N_REQ)-1:0] pick_idx,
    output logic [N_REQ-1:0]         pick_oh
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] cand;

    // Scan farthest-to-nearest so the nearest candidate overwrites the rest.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_oh = pick_valid ? (N_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/reg32_rr_arbiter.sv
// rtl/reg32_rr_arbiter.sv - round-robin arbiter sharing one register between N_REQ writers
// Optional locked bursts up to MAX_BURST writes; one-cycle bubble after a burst ends.
module reg32_rr_arbiter
    import reg32_rr_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CNT_W   = $clog2(MAX_BURST + 1);
    localparam bit LOCK_EN = (MAX_BURST > 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
    logic [IDX_W-1:0] owner_nxt;
    logic [N_REQ-1:0] gnt_nxt, ack_nxt;
    logic [WIDTH-1:0] q_nxt;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_data;
    logic [N_REQ-1:0] owner_oh;
    logic             owned_write;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .pick_valid(pick_valid),
        .pick_idx  (pick_idx),
        .pick_oh   (pick_oh)
    );

    // A single data mux: the picked requester while idle, the owner while locked.
    assign sel_idx  = (state == ST_IDLE) ? pick_idx : owner;
    assign owner_oh = N_REQ'(1) << owner;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDX_W'(k) == sel_idx) begin
                sel_data = wdata[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = burst_cnt;
        owner_nxt   = owner;
        gnt_nxt     = gnt;
        ack_nxt     = '0;
        q_nxt       = q;
        owned_write = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    q_nxt     = sel_data;
                    ack_nxt   = pick_oh;
                    gnt_nxt   = pick_oh;
                    owner_nxt = pick_idx;
                    if (lock[pick_idx] && LOCK_EN) begin
                        state_nxt = ST_OWNED;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        ptr_nxt = next_idx(pick_idx);
                    end
                end else begin
                    gnt_nxt = '0;
                end
            end
            ST_OWNED: begin
                owned_write = req[owner];
                if (owned_write) begin
                    q_nxt   = sel_data;
                    ack_nxt = owner_oh;
                    cnt_nxt = burst_cnt + CNT_W'(1);
                end
                // The write on this edge counts toward the burst limit before the exit test.
                if (!owned_write || !lock[owner] || (int'(burst_cnt) + 1 == MAX_BURST)) begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    ptr_nxt   = next_idx(owner);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            owner     <= '0;
            gnt       <= '0;
            ack       <= '0;
            q         <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= cnt_nxt;
            owner     <= owner_nxt;
            gnt       <= gnt_nxt;
            ack       <= ack_nxt;
            q         <= q_nxt;
        end
    end

    assign busy = (state == ST_OWNED);

endmodule

// File: tb/tb_reg32_rr_arbiter.sv
// tb/tb_reg32_rr_arbiter.sv - self-checking bench for reg32_rr_arbiter
module tb_reg32_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req, lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt, ack;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q;
    logic [W-1:0]   wd [N];

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [W-1:0] m_q;
    logic [N-1:0] m_gnt, m_ack;
    int           m_owner, m_ptr, m_burst;
    bit           m_owned;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] ack;
        logic [N-1:0] gnt;
        logic         busy;
        logic [1:0]   own;
        logic [W-1:0] q;
    } vec_t;

    vec_t tbl [12];

    always #10 clk = ~clk;

    always_comb begin
        wdata = '0;
        for (int i = 0; i < N; i++) wdata[i*W +: W] = wd[i];
    end

    reg32_rr_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .MAX_BURST(MB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .gnt    (gnt),
        .ack    (ack),
        .owner  (owner),
        .busy   (busy),
        .q      (q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] eq, input logic [N-1:0] egnt,
                           input logic [N-1:0] eack, input logic ebusy, input logic [1:0] eown);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_gnt"}, 32'(gnt), 32'(egnt));
        chk({tag, "_ack"}, 32'(ack), 32'(eack));
        chk({tag, "_busy"}, 32'(busy), 32'(ebusy));
        chk({tag, "_owner"}, 32'(owner), 32'(eown));
    endtask

    task automatic model_reset();
        m_q = '0; m_gnt = '0; m_ack = '0;
        m_owner = 0; m_ptr = 0; m_burst = 0; m_owned = 0;
    endtask

    // Next-state of the arbiter from the current inputs, stated from the behaviour rules.
    task automatic ref_step();
        int w;
        m_ack = '0;
        if (!m_owned) begin
            if (req == '0) begin
                m_gnt = '0;
            end else begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_q     = wd[w];
                m_ack   = 4'(1 << w);
                m_gnt   = m_ack;
                m_owner = w;
                if (lock[w] && MB > 1) begin
                    m_owned = 1;
                    m_burst = 1;
                end else begin
                    m_ptr = (w + 1) % N;
                end
            end
        end else begin
            if (req[m_owner]) begin
                m_q   = wd[m_owner];
                m_ack = 4'(1 << m_owner);
                m_burst++;
            end
            if (!req[m_owner] || !lock[m_owner] || m_burst == MB) begin
                m_owned = 0;
                m_gnt   = '0;
                m_burst = 0;
                m_ptr   = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk_out(tag, m_q, m_gnt, m_ack, m_owned, 2'(m_owner));
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0001, 1'b0, 2'd0, 32'h98765432};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b0, 2'd1, 32'h98765433};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0100, 1'b0, 2'd2, 32'h98765434};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b1000, 1'b0, 2'd3, 32'h98765435};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0001, 1'b0, 2'd0, 32'h98765432};
        tbl[5]  = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 32'h98765433};
        tbl[6]  = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 32'h98765433};
        tbl[7]  = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 32'h98765433};
        tbl[8]  = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd1, 32'h98765433};
        tbl[9]  = '{4'b0011, 4'b0010, 4'b0001, 4'b0001, 1'b0, 2'd0, 32'h98765432};
        tbl[10] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 32'h98765433};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 32'h98765433};

        reset_n = 1'b0;
        req = '0;
        lock = '0;
        for (int i = 0; i < N; i++) wd[i] = '0;
        tick();
        tick();
        chk_out("reset", 32'h0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        reset_n = 1'b1;

        // single requester write, then idle
        req = 4'b0001;
        wd[0] = 32'h12345678;
        tick();
        chk_out("single", 32'h12345678, 4'b0001, 4'b0001, 1'b0, 2'd0);
        req = 4'b0000;
        tick();
        chk_out("idle_hold", 32'h12345678, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // asynchronous reset mid-cycle after q is loaded
        req = 4'b0001;
        tick();
        chk_out("reload", 32'h12345678, 4'b0001, 4'b0001, 1'b0, 2'd0);
        #2 reset_n = 1'b0;
        #1 chk_out("async_rst", 32'h0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        req = 4'b0000;
        tick();
        reset_n = 1'b1;

        // table: rotation across all four, then a locked burst with bubble
        for (int i = 0; i < N; i++) wd[i] = 32'h98765432 + i;
        for (int i = 0; i < 12; i++) begin
            req  = tbl[i].req;
            lock = tbl[i].lock;
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].q, tbl[i].gnt, tbl[i].ack, tbl[i].busy, tbl[i].own);
        end

        // owner 2 locked, lock drops after its second write
        wd[0] = 32'hC0DE0000;
        wd[2] = 32'hC0DE0002;
        wd[3] = 32'hC0DE0003;
        req  = 4'b1101;
        lock = 4'b0100;
        tick();
        chk_out("lk_first", 32'hC0DE0002, 4'b0100, 4'b0100, 1'b1, 2'd2);
        tick();
        chk_out("lk_second", 32'hC0DE0002, 4'b0100, 4'b0100, 1'b1, 2'd2);
        lock = 4'b0000;
        wd[2] = 32'hC0DE0022;
        tick();
        chk_out("lk_exit", 32'hC0DE0022, 4'b0000, 4'b0100, 1'b0, 2'd2);
        tick();
        chk_out("lk_after", 32'hC0DE0003, 4'b1000, 4'b1000, 1'b0, 2'd3);
        req = 4'b0000;
        tick();
        chk_out("lk_idle", 32'hC0DE0003, 4'b0000, 4'b0000, 1'b0, 2'd3);

        // reset pulse while OWNED
        wd[2] = 32'hD0000002;
        wd[3] = 32'hD0000003;
        req  = 4'b1100;
        lock = 4'b0100;
        tick();
        chk_out("own_pre", 32'hD0000002, 4'b0100, 4'b0100, 1'b1, 2'd2);
        #2 reset_n = 1'b0;
        #1 chk_out("own_rst", 32'h0, 4'b0000, 4'b0000, 1'b0, 2'd0);
        lock = 4'b0000;
        tick();
        reset_n = 1'b1;
        tick();
        chk_out("post_rst1", 32'hD0000002, 4'b0100, 4'b0100, 1'b0, 2'd2);
        tick();
        chk_out("post_rst2", 32'hD0000003, 4'b1000, 4'b1000, 1'b0, 2'd3);

        // randomized traffic against the reference model
        req = '0;
        lock = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            req  = req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            lock = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            for (int b = 0; b < N; b++) wd[b] = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check_model($sformatf("rnd_rst%0d", i));
                reset_n = 1'b1;
                #1;
            end
            ref_step();
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
